// File: rtl/draw_arbiter.sv
// Serialises picture-print sources onto the single VGA pixel-write port, lowest index first, one full draw at a time.
// start follows a req by 2 cycles; each pixel is written 1 cycle after its X/Y so it lines up with the source's ROM colour.
module draw_arbiter #(
  parameter int N_SRC   = 9,
  parameter int XW      = 8,
  parameter int YW      = 7,
  parameter int CW      = 9,
  parameter int TO_W    = 28,
  parameter int TIMEOUT = 0
) (
  input  logic                Clock,
  input  logic                ResetN,
  input  logic [N_SRC-1:0]    req,
  input  logic [N_SRC*XW-1:0] src_x,
  input  logic [N_SRC*YW-1:0] src_y,
  input  logic [N_SRC*CW-1:0] src_colour,
  input  logic [N_SRC-1:0]    src_finish,
  output logic [N_SRC-1:0]    start,
  output logic [XW-1:0]       vga_x,
  output logic [YW-1:0]       vga_y,
  output logic [CW-1:0]       vga_colour,
  output logic                plot,
  output logic                busy,
  output logic [N_SRC-1:0]    done,
  output logic                timeout_err
);

  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LAUNCH = 2'd1, S_DRAW = 2'd2} state_t;

  state_t           r_state, w_state_nxt;
  logic [SW-1:0]    r_sel, w_sel_nxt, w_low;
  logic [N_SRC-1:0] r_pend, w_clr, w_sel_oh, r_done;
  logic [TO_W-1:0]  r_cnt;
  logic [XW-1:0]    w_sx, r_x_p, r_last_x;
  logic [YW-1:0]    w_sy, r_y_p, r_last_y;
  logic [CW-1:0]    w_sc;
  logic             w_fin, w_to_hit, w_fin_hit, w_abort, w_plot;
  logic             r_vld_p, r_first, r_to_err;

  always_comb begin
    w_sel_oh = '0;
    w_sx     = '0;
    w_sy     = '0;
    w_sc     = '0;
    w_fin    = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_sel == SW'(i)) begin
        w_sel_oh[i] = 1'b1;
        w_sx        = src_x[i*XW +: XW];
        w_sy        = src_y[i*YW +: YW];
        w_sc        = src_colour[i*CW +: CW];
        w_fin       = src_finish[i];
      end
    end
  end

  // Descending scan so the lowest pending index wins.
  always_comb begin
    w_low = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (r_pend[i]) w_low = SW'(i);
    end
  end

  assign w_to_hit = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_clr       = '0;
    w_fin_hit   = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|r_pend) begin
          w_sel_nxt   = w_low;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_clr       = w_sel_oh;
        w_state_nxt = S_DRAW;
      end
      S_DRAW: begin
        if (w_fin) begin
          w_fin_hit   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_to_hit) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      // A request in the launch cycle re-arms the source being launched.
      r_pend  <= (r_pend & ~w_clr) | req;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_cnt <= '0;
    end else if (r_state == S_LAUNCH) begin
      r_cnt <= '0;
    end else if (r_state == S_DRAW && r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_vld_p  <= 1'b0;
      r_x_p    <= '0;
      r_y_p    <= '0;
      r_first  <= 1'b0;
      r_last_x <= '0;
      r_last_y <= '0;
      r_done   <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_vld_p  <= (r_state == S_DRAW) && !w_fin && !w_abort;
      r_x_p    <= w_sx;
      r_y_p    <= w_sy;
      r_done   <= w_fin_hit ? w_sel_oh : '0;
      r_to_err <= w_abort;
      if (r_state == S_LAUNCH) begin
        r_first <= 1'b1;
      end else if (w_plot) begin
        r_first <= 1'b0;
      end
      if (w_plot) begin
        r_last_x <= r_x_p;
        r_last_y <= r_y_p;
      end
    end
  end

  // A source parked on one coordinate yields a single write, not a stream.
  assign w_plot = r_vld_p && (r_first || ({r_x_p, r_y_p} != {r_last_x, r_last_y}));

  assign plot        = w_plot;
  assign vga_x       = r_x_p;
  assign vga_y       = r_y_p;
  assign vga_colour  = r_vld_p ? w_sc : '0;
  assign start       = (r_state == S_LAUNCH) ? w_sel_oh : '0;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign timeout_err = r_to_err;

endmodule

// File: tb/tb_draw_arbiter.sv
// Randomised bench for draw_arbiter: scan-stub sources, a timestamp-based reference model checked every cycle,
// plus literal pins for the scan, priority, hold-dedupe, watchdog and mid-draw reset scenarios.
module tb_draw_arbiter;
  localparam int N   = 9;
  localparam int XW  = 8;
  localparam int YW  = 7;
  localparam int CW  = 9;
  localparam int TMO = 20000;

  logic            Clock, ResetN;
  logic [N-1:0]    req, src_finish, start, done;
  logic [N*XW-1:0] src_x;
  logic [N*YW-1:0] src_y;
  logic [N*CW-1:0] src_colour;
  logic [XW-1:0]   vga_x;
  logic [YW-1:0]   vga_y;
  logic [CW-1:0]   vga_colour;
  logic            plot, busy, timeout_err;

  draw_arbiter #(.N_SRC(N), .XW(XW), .YW(YW), .CW(CW), .TO_W(28), .TIMEOUT(TMO)) dut (
    .Clock(Clock), .ResetN(ResetN), .req(req), .src_x(src_x), .src_y(src_y),
    .src_colour(src_colour), .src_finish(src_finish), .start(start), .vga_x(vga_x),
    .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot), .busy(busy), .done(done),
    .timeout_err(timeout_err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [CW-1:0] col_fn(input int i, input int x, input int y);
    return CW'((x * 3 + y * 5 + i * 17) & 511);
  endfunction

  // Source stubs: scan W x H from a base, optionally park on one coordinate, then pulse finish.
  int s_w[N], s_h[N], s_bx[N], s_by[N], s_hold[N], s_hx[N], s_hy[N], s_k[N], px[N], py[N];
  bit s_nofin[N], s_act[N];

  task automatic cfg(input int i, input int w, input int h, input int bx, input int by,
                     input int hd, input int hx, input int hy, input bit nofin);
    s_w[i] = w; s_h[i] = h; s_bx[i] = bx; s_by[i] = by;
    s_hold[i] = hd; s_hx[i] = hx; s_hy[i] = hy; s_nofin[i] = nofin;
  endtask

  task automatic rand_cfg(input int i);
    int w, h, bx, by, hd, mode, hx, hy;
    w = $urandom_range(1, 12); h = $urandom_range(1, 3);
    bx = $urandom_range(0, 243); by = $urandom_range(0, 124);
    hd = $urandom_range(0, 4); mode = $urandom_range(0, 2);
    if (mode == 0) begin hx = bx + w - 1; hy = by + h - 1; end
    else if (mode == 1) begin hx = bx; hy = by; end
    else begin hx = $urandom_range(0, 255); hy = $urandom_range(0, 127); end
    cfg(i, w, h, bx, by, hd, hx, hy, 1'b0);
  endtask

  initial begin
    int x, y, n;
    logic f;
    src_x = '0; src_y = '0; src_colour = '0; src_finish = '0;
    for (int i = 0; i < N; i++) begin
      s_act[i] = 0; px[i] = 0; py[i] = 0; s_k[i] = 0;
    end
    forever begin
      @(negedge Clock);
      for (int i = 0; i < N; i++) begin
        if (!ResetN || !busy) s_act[i] = 0;
        if (ResetN && start[i]) begin s_act[i] = 1; s_k[i] = 0; end
      end
      @(posedge Clock); #1;
      for (int i = 0; i < N; i++) begin
        src_colour[i*CW +: CW] = col_fn(i, px[i], py[i]);
        x = px[i]; y = py[i]; f = 1'b0;
        if (s_act[i]) begin
          n = s_w[i] * s_h[i];
          if (s_nofin[i] && s_k[i] >= n + s_hold[i]) s_k[i] = 0;
          if (s_k[i] < n) begin
            x = s_bx[i] + s_k[i] % s_w[i];
            y = s_by[i] + s_k[i] / s_w[i];
          end else if (s_k[i] < n + s_hold[i]) begin
            x = s_hx[i]; y = s_hy[i];
          end else begin
            f = 1'b1; s_act[i] = 0;
          end
          s_k[i]++;
        end else begin
          x = $urandom_range(0, 255); y = $urandom_range(0, 127);
          f = ($urandom_range(0, 15) == 0);
        end
        src_x[i*XW +: XW] = XW'(x);
        src_y[i*YW +: YW] = YW'(y);
        src_finish[i]     = f;
        px[i] = x; py[i] = y;
      end
    end
  end

  // Reference model: one active draw identified by its launch cycle; everything else follows from timestamps.
  bit [N-1:0] m_pend, e_done;
  int m_cur = -1, m_L = 0, m_lx = 0, m_ly = 0, e_x = 0, e_y = 0, e_src = 0;
  bit m_first, e_plot, e_to;
  int n_start[N], n_done[N], start_cyc[N], done_cyc[N];
  int run_plots = 0, fp_cyc = -1, fp_x = 0, fp_y = 0, lp_cyc = 0, lp_x = 0, lp_y = 0;
  int to_cnt = 0, to_cyc = 0, start_total = 0;

  initial begin
    logic [N-1:0] exp_start;
    bit exp_busy;
    int d, x, y;
    for (int i = 0; i < N; i++) begin n_start[i] = 0; n_done[i] = 0; start_cyc[i] = 0; done_cyc[i] = 0; end
    forever begin
      @(negedge Clock);
      cyc++;
      if (!ResetN) begin
        chk("rst_plot", 32'(plot), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        chk("rst_vga", 32'({vga_x, vga_y, vga_colour}), 0);
        m_pend = '0; m_cur = -1; e_plot = 0; e_done = '0; e_to = 0;
      end else begin
        exp_busy  = (m_cur >= 0) && (cyc >= m_L);
        exp_start = '0;
        if (m_cur >= 0 && cyc == m_L) exp_start[m_cur] = 1'b1;
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("start", 32'(start), 32'(exp_start));
        chk("done", 32'(done), 32'(e_done));
        chk("timeout_err", 32'(timeout_err), 32'(e_to));
        chk("plot", 32'(plot), 32'(e_plot));
        if (e_plot) begin
          chk("vga_x", 32'(vga_x), e_x);
          chk("vga_y", 32'(vga_y), e_y);
          chk("vga_colour", 32'(vga_colour), 32'(col_fn(e_src, e_x, e_y)));
        end
        for (int i = 0; i < N; i++) begin
          if (start[i]) begin
            start_cyc[i] = cyc; n_start[i]++; start_total++; run_plots = 0; fp_cyc = -1;
          end
          if (done[i]) begin done_cyc[i] = cyc; n_done[i]++; end
        end
        if (plot) begin
          run_plots++;
          if (fp_cyc < 0) begin fp_cyc = cyc; fp_x = vga_x; fp_y = vga_y; end
          lp_cyc = cyc; lp_x = vga_x; lp_y = vga_y;
        end
        if (timeout_err) begin to_cnt++; to_cyc = cyc; end

        e_done = '0; e_to = 0; e_plot = 0;
        if (m_cur >= 0 && cyc > m_L) begin
          d = cyc - m_L;
          if (src_finish[m_cur]) begin
            e_done[m_cur] = 1'b1; m_cur = -1;
          end else if (d == TMO) begin
            e_to = 1; m_cur = -1;
          end else begin
            x = src_x[m_cur*XW +: XW];
            y = src_y[m_cur*YW +: YW];
            if (m_first || x != m_lx || y != m_ly) begin
              e_plot = 1; e_x = x; e_y = y; e_src = m_cur;
              m_first = 0; m_lx = x; m_ly = y;
            end
          end
        end else if (m_cur < 0 && m_pend != 0) begin
          for (int i = N - 1; i >= 0; i--) if (m_pend[i]) m_cur = i;
          m_L = cyc + 1; m_first = 1;
        end
        if (m_cur >= 0 && cyc == m_L) m_pend[m_cur] = 1'b0;
        m_pend |= req;
      end
    end
  end

  task automatic pulse(input logic [N-1:0] m);
    @(posedge Clock); #1; req = m;
    @(posedge Clock); #1; req = '0;
  endtask

  task automatic wait_evt(input string nm, input int i, input bit want_done, input int budget);
    int b, t;
    b = want_done ? n_done[i] : n_start[i];
    t = 0;
    while (((want_done ? n_done[i] : n_start[i]) == b) && t < budget) begin
      @(negedge Clock); #1; t++;
    end
    chk(nm, 32'((want_done ? n_done[i] : n_start[i]) != b), 1);
  endtask

  initial begin
    int s0, hold_left, to0, d5;
    logic [N-1:0] m;
    ResetN = 1'b0; req = '0;
    for (int i = 0; i < N; i++) cfg(i, 4, 2, 10 * i, 5 * i, 0, 0, 0, 1'b0);
    repeat (3) @(posedge Clock);
    #1 ResetN = 1'b1;
    repeat (3) @(posedge Clock);

    // Full-screen scan on source 0.
    cfg(0, 160, 120, 0, 0, 0, 0, 0, 1'b0);
    pulse(9'b000000001);
    wait_evt("t1_done", 0, 1, 20000);
    chk("t1_plots", run_plots, 19200);
    chk("t1_first_lat", fp_cyc - start_cyc[0], 2);
    chk("t1_first_xy", {fp_x[15:0], fp_y[15:0]}, {16'd0, 16'd0});
    chk("t1_last_xy", {lp_x[15:0], lp_y[15:0]}, {16'd159, 16'd119});
    chk("t1_done_lat", done_cyc[0] - lp_cyc, 1);

    // Simultaneous requests: index order, back-to-back.
    cfg(0, 10, 3, 5, 5, 0, 0, 0, 1'b0);
    cfg(2, 6, 2, 50, 60, 0, 0, 0, 1'b0);
    pulse(9'b000000101);
    wait_evt("t2_done2", 2, 1, 500);
    chk("t2_order", 32'(done_cyc[0] < done_cyc[2]), 1);
    chk("t2_start2", start_cyc[2] - done_cyc[0], 1);

    // Request arriving mid-draw waits its turn.
    cfg(0, 20, 5, 30, 40, 0, 0, 0, 1'b0);
    pulse(9'b000000001);
    repeat (10) @(posedge Clock);
    pulse(9'b000010000);
    wait_evt("t3_done4", 4, 1, 500);
    chk("t3_start4", start_cyc[4] - done_cyc[0], 1);

    // Label-like stub that parks on its base before finishing.
    cfg(3, 79, 8, 14, 10, 1000, 14, 10, 1'b0);
    pulse(9'b000001000);
    wait_evt("t4_done", 3, 1, 2000);
    chk("t4_plots", run_plots, 633);
    chk("t4_last_xy", {lp_x[15:0], lp_y[15:0]}, {16'd14, 16'd10});

    // Watchdog abort, then the next pending source launches.
    to0 = to_cnt; d5 = n_done[5];
    cfg(5, 30, 4, 100, 20, 0, 0, 0, 1'b1);
    cfg(6, 5, 2, 200, 100, 0, 0, 0, 1'b0);
    pulse(9'b000100000);
    repeat (5) @(posedge Clock);
    pulse(9'b001000000);
    wait_evt("t5_start6", 6, 0, TMO + 100);
    chk("t5_to_count", to_cnt - to0, 1);
    chk("t5_no_done5", n_done[5] - d5, 0);
    chk("t5_to_lat", to_cyc - start_cyc[5], TMO + 1);
    chk("t5_start6", start_cyc[6] - to_cyc, 1);
    wait_evt("t5_done6", 6, 1, 200);

    // Asynchronous reset in the middle of a draw, with another request pending.
    cfg(1, 40, 20, 60, 30, 0, 0, 0, 1'b0);
    pulse(9'b000000010);
    repeat (40) @(posedge Clock);
    pulse(9'b010000000);
    repeat (10) @(posedge Clock);
    #2;
    chk("t6_pre_busy", 32'(busy), 1);
    chk("t6_pre_plot", 32'(plot), 1);
    #1 ResetN = 1'b0;
    #1;
    chk("t6_plot_drop", 32'(plot), 0);
    chk("t6_busy_drop", 32'(busy), 0);
    chk("t6_start_drop", 32'(start), 0);
    repeat (3) @(posedge Clock);
    #1 ResetN = 1'b1;
    s0 = start_total;
    repeat (20) @(negedge Clock);
    #1;
    chk("t6_no_launch", start_total - s0, 0);

    // Random traffic: pulses and short levels, re-arms, parked coordinates.
    hold_left = 0;
    for (int c = 0; c < 6000; c++) begin
      @(posedge Clock); #1;
      if (hold_left > 0) begin
        hold_left--;
      end else begin
        req = '0;
        if ($urandom_range(0, 9) == 0) begin
          m = N'($urandom) & N'($urandom);
          for (int i = 0; i < N; i++) if (m[i] && !s_act[i]) rand_cfg(i);
          req = m;
          hold_left = $urandom_range(0, 2);
        end
      end
    end
    @(posedge Clock); #1; req = '0;
    repeat (1500) @(negedge Clock);
    #1;
    chk("final_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
